// File: rtl/fpu_defs_div_sqrt.sv
// -----------------------------------------------------------------------------
// fpu_defs_div_sqrt
//   Shared definitions for the div/sqrt unpacking front end: IEEE-754 single
//   field widths, the exponent bias, the unpack FSM state encoding, the
//   per-operand classification record and the provisional result exponent
//   helper used both at job load and during mantissa normalization.
// -----------------------------------------------------------------------------
package fpu_defs_div_sqrt;

  localparam int C_OP   = 32;
  localparam int C_EXP  = 8;
  localparam int C_MANT = 23;
  localparam int C_RM   = 3;
  localparam int C_BIAS = 127;

  // Working exponent width: two guard bits so denormal pre-shifts and the
  // a - b + bias difference stay representable as a signed value.
  localparam int C_EXP_W = C_EXP + 2;

  localparam logic signed [C_EXP_W-1:0] EXP_ONE  = C_EXP_W'(1);
  localparam logic signed [C_EXP_W-1:0] EXP_BIAS = C_EXP_W'(C_BIAS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } unpack_state_e;

  // Classification of one operand. eff_exp is the biased exponent with the
  // denormal convention applied (field 0 with nonzero fraction reads as 1).
  typedef struct packed {
    logic                       sign;
    logic signed [C_EXP_W-1:0]  eff_exp;
    logic [C_MANT:0]            mant;
    logic                       nan;
    logic                       inf;
    logic                       zero;
    logic                       denorm;
  } op_class_t;

  typedef struct packed {
    logic signed [C_EXP_W-1:0] exp;
    logic                      odd;
  } exp_res_t;

  // Provisional biased result exponent.
  //   div : Ea - Eb + bias
  //   sqrt: (Ea + bias) / 2, with the dropped LSB reported as "odd" so the
  //         core can pre-shift the mantissa by one.
  // The sqrt sum is always positive for any single-precision input, so the
  // arithmetic shift never sees a negative operand. No saturation is applied.
  function automatic exp_res_t calc_exp(input logic                      div,
                                        input logic signed [C_EXP_W-1:0] exp_a,
                                        input logic signed [C_EXP_W-1:0] exp_b);
    exp_res_t                  res;
    logic signed [C_EXP_W-1:0] sum;
    sum = exp_a + EXP_BIAS;
    if (div) begin
      res.exp = exp_a - exp_b + EXP_BIAS;
      res.odd = 1'b0;
    end else begin
      res.exp = sum >>> 1;
      res.odd = sum[0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fpu_class_div_sqrt.sv
// -----------------------------------------------------------------------------
// fpu_class_div_sqrt
//   Combinational classifier for a single IEEE-754 single-precision operand.
//
//   operand : raw 32-bit encoding
//   info    : {sign, eff_exp, mant24, nan, inf, zero, denorm}
//
//   mant24 carries the explicit hidden bit: 1 for normal/Inf/NaN encodings,
//   0 for denormals and zero, so a zero operand yields an all-zero mantissa.
// -----------------------------------------------------------------------------
module fpu_class_div_sqrt
  import fpu_defs_div_sqrt::*;
(
  input  logic [C_OP-1:0] operand,
  output op_class_t       info
);

  logic [C_EXP-1:0]  exp_field;
  logic [C_MANT-1:0] frac;
  logic              exp_max;
  logic              exp_zero;
  logic              frac_zero;

  assign exp_field = operand[C_OP-2 -: C_EXP];
  assign frac      = operand[C_MANT-1:0];
  assign exp_max   = &exp_field;
  assign exp_zero  = ~|exp_field;
  assign frac_zero = ~|frac;

  // NOTE: every field is assigned on every pass through this block; a field
  // left unassigned on some path would infer a latch.
  always_comb begin
    info.sign    = operand[C_OP-1];
    info.nan     = exp_max & ~frac_zero;
    info.inf     = exp_max & frac_zero;
    info.zero    = exp_zero & frac_zero;
    info.denorm  = exp_zero & ~frac_zero;
    info.mant    = {~exp_zero, frac};
    info.eff_exp = info.denorm ? EXP_ONE : $signed({2'b00, exp_field});
  end

endmodule

// File: rtl/fpu_unpack_div_sqrt.sv
// -----------------------------------------------------------------------------
// fpu_unpack_div_sqrt
//   Operand unpack / pre-normalization stage in front of the iterative
//   div/sqrt mantissa core. Accepts a job, classifies both operands,
//   left-normalizes denormal mantissas one bit per cycle, computes the
//   provisional sign and exponent and holds the result behind a valid/ready
//   register stage.
//
//   Clk_CI, Rst_RBI          clock, synchronous active-low reset
//   Div_start_SI             start a / b (wins if both starts are high)
//   Sqrt_start_SI            start sqrt(a); b is ignored
//   Operand_a_DI/_b_DI       raw IEEE single operands
//   RM_SI                    rounding mode, captured on accept
//   Ready_SO                 a start is accepted this cycle
//   Ready_SI                 downstream takes the held result
//   Valid_SO                 result registers hold a finished job
//   Mant_a_DO/_b_DO          normalized 24-bit mantissas (0 for zero)
//   Exp_DO                   provisional biased result exponent (signed)
//   Exp_odd_SO               sqrt: exponent odd, core pre-shifts mantissa
//   Sign_DO                  result sign
//   Operand_a/b_dly_DO       captured raw operands
//   Inf/Zero/NaN_a/b_SO      operand class flags (b flags 0 for sqrt)
//   Invalid_SO               0/0, Inf/Inf or sqrt of negative nonzero value
//   Special_SO               result decided by class flags alone
//   Div/Sqrt_enable_SO       captured operation
//   RM_dly_SO                captured rounding mode
// -----------------------------------------------------------------------------
module fpu_unpack_div_sqrt
  import fpu_defs_div_sqrt::*;
(
  input  logic                     Clk_CI,
  input  logic                     Rst_RBI,
  input  logic                     Div_start_SI,
  input  logic                     Sqrt_start_SI,
  input  logic [C_OP-1:0]          Operand_a_DI,
  input  logic [C_OP-1:0]          Operand_b_DI,
  input  logic [C_RM-1:0]          RM_SI,
  output logic                     Ready_SO,
  input  logic                     Ready_SI,
  output logic                     Valid_SO,
  output logic [C_MANT:0]          Mant_a_DO,
  output logic [C_MANT:0]          Mant_b_DO,
  output logic signed [C_EXP+1:0]  Exp_DO,
  output logic                     Exp_odd_SO,
  output logic                     Sign_DO,
  output logic [C_OP-1:0]          Operand_a_dly_DO,
  output logic [C_OP-1:0]          Operand_b_dly_DO,
  output logic                     Inf_a_SO,
  output logic                     Inf_b_SO,
  output logic                     Zero_a_SO,
  output logic                     Zero_b_SO,
  output logic                     NaN_a_SO,
  output logic                     NaN_b_SO,
  output logic                     Invalid_SO,
  output logic                     Special_SO,
  output logic                     Div_enable_SO,
  output logic                     Sqrt_enable_SO,
  output logic [C_RM-1:0]          RM_dly_SO
);

  unpack_state_e state_q;

  // Effective exponents of the operands; they track the normalization
  // shifts so the result exponent can be recomputed each NORM cycle.
  logic signed [C_EXP_W-1:0] exp_a_q;
  logic signed [C_EXP_W-1:0] exp_b_q;

  op_class_t cls_a;
  op_class_t cls_b;

  fpu_class_div_sqrt u_class_a (
    .operand (Operand_a_DI),
    .info    (cls_a)
  );

  fpu_class_div_sqrt u_class_b (
    .operand (Operand_b_DI),
    .info    (cls_b)
  );

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;

  assign Ready_SO = (state_q == IDLE) | ((state_q == DONE) & Ready_SI);
  assign accept   = (Div_start_SI | Sqrt_start_SI) & Ready_SO;

  // ---------------------------------------------------------------------------
  // Load-path values (new job) and one NORM step (current job)
  // ---------------------------------------------------------------------------
  logic                      ld_div;
  op_class_t                 cls_b_rel;
  logic                      ld_sign;
  logic                      ld_invalid;
  logic                      ld_special;
  logic                      ld_need_norm;
  exp_res_t                  ld_exp;

  logic                      shift_a;
  logic                      shift_b;
  logic [C_MANT:0]           nrm_mant_a;
  logic [C_MANT:0]           nrm_mant_b;
  logic signed [C_EXP_W-1:0] nrm_exp_a;
  logic signed [C_EXP_W-1:0] nrm_exp_b;
  logic                      nrm_done;
  exp_res_t                  nrm_exp;

  always_comb begin
    // Division has priority when both starts are raised.
    ld_div = Div_start_SI;

    // Operand b does not take part in sqrt; blank it so its flags,
    // mantissa and exponent cannot leak into the job.
    cls_b_rel = cls_b;
    if (!ld_div) cls_b_rel = '0;

    ld_sign = ld_div ? (cls_a.sign ^ cls_b.sign) : cls_a.sign;

    if (ld_div) begin
      ld_invalid = (cls_a.zero & cls_b.zero) | (cls_a.inf & cls_b.inf);
    end else begin
      ld_invalid = cls_a.sign & ~cls_a.zero & ~cls_a.nan;
    end

    ld_special = cls_a.nan | cls_b_rel.nan | cls_a.inf | cls_b_rel.inf |
                 cls_a.zero | cls_b_rel.zero | ld_invalid;

    // The classifier only flags denorm for nonzero, finite encodings.
    ld_need_norm = cls_a.denorm | cls_b_rel.denorm;

    ld_exp = calc_exp(ld_div, cls_a.eff_exp, cls_b_rel.eff_exp);

    // A zero mantissa would never reach a leading 1, so zero operands are
    // excluded; NaN/Inf already carry the hidden 1 and never qualify.
    shift_a = ~Mant_a_DO[C_MANT] & ~Zero_a_SO;
    shift_b = ~Mant_b_DO[C_MANT] & ~Zero_b_SO & Div_enable_SO;

    nrm_mant_a = shift_a ? {Mant_a_DO[C_MANT-1:0], 1'b0} : Mant_a_DO;
    nrm_mant_b = shift_b ? {Mant_b_DO[C_MANT-1:0], 1'b0} : Mant_b_DO;
    nrm_exp_a  = shift_a ? (exp_a_q - EXP_ONE) : exp_a_q;
    nrm_exp_b  = shift_b ? (exp_b_q - EXP_ONE) : exp_b_q;

    nrm_done = (nrm_mant_a[C_MANT] | Zero_a_SO) &
               (~Div_enable_SO | nrm_mant_b[C_MANT] | Zero_b_SO);

    nrm_exp = calc_exp(Div_enable_SO, nrm_exp_a, nrm_exp_b);
  end

  // ---------------------------------------------------------------------------
  // State and result registers
  // ---------------------------------------------------------------------------
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of the
  // statement order inside the block.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q          <= IDLE;
      Valid_SO         <= 1'b0;
      exp_a_q          <= '0;
      exp_b_q          <= '0;
      Mant_a_DO        <= '0;
      Mant_b_DO        <= '0;
      Exp_DO           <= '0;
      Exp_odd_SO       <= 1'b0;
      Sign_DO          <= 1'b0;
      Operand_a_dly_DO <= '0;
      Operand_b_dly_DO <= '0;
      Inf_a_SO         <= 1'b0;
      Inf_b_SO         <= 1'b0;
      Zero_a_SO        <= 1'b0;
      Zero_b_SO        <= 1'b0;
      NaN_a_SO         <= 1'b0;
      NaN_b_SO         <= 1'b0;
      Invalid_SO       <= 1'b0;
      Special_SO       <= 1'b0;
      Div_enable_SO    <= 1'b0;
      Sqrt_enable_SO   <= 1'b0;
      RM_dly_SO        <= '0;
    end else if (accept) begin
      // New job: from IDLE, or back-to-back with a DONE handshake.
      state_q          <= ld_need_norm ? NORM : DONE;
      Valid_SO         <= ~ld_need_norm;
      exp_a_q          <= cls_a.eff_exp;
      exp_b_q          <= cls_b_rel.eff_exp;
      Mant_a_DO        <= cls_a.mant;
      Mant_b_DO        <= cls_b_rel.mant;
      Exp_DO           <= ld_exp.exp;
      Exp_odd_SO       <= ld_exp.odd;
      Sign_DO          <= ld_sign;
      Operand_a_dly_DO <= Operand_a_DI;
      Operand_b_dly_DO <= Operand_b_DI;
      Inf_a_SO         <= cls_a.inf;
      Inf_b_SO         <= cls_b_rel.inf;
      Zero_a_SO        <= cls_a.zero;
      Zero_b_SO        <= cls_b_rel.zero;
      NaN_a_SO         <= cls_a.nan;
      NaN_b_SO         <= cls_b_rel.nan;
      Invalid_SO       <= ld_invalid;
      Special_SO       <= ld_special;
      Div_enable_SO    <= ld_div;
      Sqrt_enable_SO   <= ~ld_div;
      RM_dly_SO        <= RM_SI;
    end else begin
      unique case (state_q)
        NORM: begin
          Mant_a_DO  <= nrm_mant_a;
          Mant_b_DO  <= nrm_mant_b;
          exp_a_q    <= nrm_exp_a;
          exp_b_q    <= nrm_exp_b;
          Exp_DO     <= nrm_exp.exp;
          Exp_odd_SO <= nrm_exp.odd;
          if (nrm_done) begin
            state_q  <= DONE;
            Valid_SO <= 1'b1;
          end
        end
        DONE: begin
          // Handshake without a new start: release the result registers.
          if (Ready_SI) begin
            state_q  <= IDLE;
            Valid_SO <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_unpack_div_sqrt.sv
// -----------------------------------------------------------------------------
// tb_fpu_unpack_div_sqrt
//   Self-checking bench for fpu_unpack_div_sqrt. Jobs come from a table of
//   {inputs, expected outputs}; expected results are queued when the DUT
//   accepts a job and compared when the DUT hands the result over.
//   Hand-written sequences cover streaming, DONE back-pressure with an
//   ignored start, back-to-back reload and reset during NORM.
// -----------------------------------------------------------------------------
module tb_fpu_unpack_div_sqrt;

  typedef struct packed {
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic [9:0]  exp;
    logic        exp_odd;
    logic        sign;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        inf_a;
    logic        inf_b;
    logic        zero_a;
    logic        zero_b;
    logic        nan_a;
    logic        nan_b;
    logic        invalid;
    logic        special;
    logic        div_en;
    logic        sqrt_en;
    logic [2:0]  rm;
  } res_t;

  typedef struct {
    logic        dv;
    logic        sq;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    res_t        res;
    int          lat;
  } vec_t;

  typedef struct {
    int   id;
    res_t res;
    int   lat;
    int   cyc;
    bit   lat_chk;
  } sb_t;

  localparam int NVEC = 15;

  logic               clk;
  logic               rst_n;
  logic               div_start;
  logic               sqrt_start;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [2:0]         rm;
  logic               ready_so;
  logic               ready_in;
  logic               valid;
  logic [23:0]        mant_a;
  logic [23:0]        mant_b;
  logic signed [9:0]  exp_o;
  logic               exp_odd;
  logic               sign;
  logic [31:0]        op_a_dly;
  logic [31:0]        op_b_dly;
  logic               inf_a;
  logic               inf_b;
  logic               zero_a;
  logic               zero_b;
  logic               nan_a;
  logic               nan_b;
  logic               invalid;
  logic               special;
  logic               div_en;
  logic               sqrt_en;
  logic [2:0]         rm_dly;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  sb_t  sb[$];
  vec_t vecs[NVEC];

  fpu_unpack_div_sqrt dut (
    .Clk_CI           (clk),
    .Rst_RBI          (rst_n),
    .Div_start_SI     (div_start),
    .Sqrt_start_SI    (sqrt_start),
    .Operand_a_DI     (op_a),
    .Operand_b_DI     (op_b),
    .RM_SI            (rm),
    .Ready_SO         (ready_so),
    .Ready_SI         (ready_in),
    .Valid_SO         (valid),
    .Mant_a_DO        (mant_a),
    .Mant_b_DO        (mant_b),
    .Exp_DO           (exp_o),
    .Exp_odd_SO       (exp_odd),
    .Sign_DO          (sign),
    .Operand_a_dly_DO (op_a_dly),
    .Operand_b_dly_DO (op_b_dly),
    .Inf_a_SO         (inf_a),
    .Inf_b_SO         (inf_b),
    .Zero_a_SO        (zero_a),
    .Zero_b_SO        (zero_b),
    .NaN_a_SO         (nan_a),
    .NaN_b_SO         (nan_b),
    .Invalid_SO       (invalid),
    .Special_SO       (special),
    .Div_enable_SO    (div_en),
    .Sqrt_enable_SO   (sqrt_en),
    .RM_dly_SO        (rm_dly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // fl = {inf_a, inf_b, zero_a, zero_b, nan_a, nan_b, invalid, special, div_en, sqrt_en}
  function automatic vec_t mk(input logic dv, input logic sq, input logic [31:0] a,
                              input logic [31:0] b, input logic [2:0] r,
                              input logic [23:0] ma, input logic [23:0] mb,
                              input logic [9:0] e, input logic odd, input logic s,
                              input logic [9:0] fl, input int lat);
    vec_t v;
    v.dv = dv; v.sq = sq; v.a = a; v.b = b; v.rm = r; v.lat = lat;
    v.res.mant_a  = ma;    v.res.mant_b  = mb;
    v.res.exp     = e;     v.res.exp_odd = odd;  v.res.sign = s;
    v.res.op_a    = a;     v.res.op_b    = b;    v.res.rm   = r;
    v.res.inf_a   = fl[9]; v.res.inf_b   = fl[8];
    v.res.zero_a  = fl[7]; v.res.zero_b  = fl[6];
    v.res.nan_a   = fl[5]; v.res.nan_b   = fl[4];
    v.res.invalid = fl[3]; v.res.special = fl[2];
    v.res.div_en  = fl[1]; v.res.sqrt_en = fl[0];
    return v;
  endfunction

  function automatic res_t get_actual();
    res_t r;
    r.mant_a = mant_a;  r.mant_b = mant_b;  r.exp = exp_o;  r.exp_odd = exp_odd;
    r.sign = sign;      r.op_a = op_a_dly;  r.op_b = op_b_dly;
    r.inf_a = inf_a;    r.inf_b = inf_b;    r.zero_a = zero_a; r.zero_b = zero_b;
    r.nan_a = nan_a;    r.nan_b = nan_b;    r.invalid = invalid; r.special = special;
    r.div_en = div_en;  r.sqrt_en = sqrt_en; r.rm = rm_dly;
    return r;
  endfunction

  // Scoreboard consumer: every handshake must match the oldest queued job.
  always @(negedge clk) begin
    if (valid && ready_in) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 expected no outstanding job");
      end else begin
        sb_t e;
        e = sb.pop_front();
        check($sformatf("job%0d_result", e.id), get_actual(), e.res);
        if (e.lat_chk) check($sformatf("job%0d_latency", e.id), cyc - e.cyc, e.lat);
      end
    end
  end

  task automatic idle();
    div_start  = 1'b0;
    sqrt_start = 1'b0;
  endtask

  // Raises the start and waits (bounded) for the DUT to take it. Returns at
  // posedge+1 after the accepting edge with the start still raised.
  task automatic drive_job(input vec_t v, input int id, input bit push,
                           input bit lat_chk, output int waited);
    bit  accepted;
    sb_t e;
    div_start  = v.dv;
    sqrt_start = v.sq;
    op_a       = v.a;
    op_b       = v.b;
    rm         = v.rm;
    waited     = 0;
    accepted   = 0;
    while (!accepted && waited < 100) begin
      @(negedge clk);
      if (ready_so) begin
        if (push) begin
          e.id = id; e.res = v.res; e.lat = v.lat; e.cyc = cyc; e.lat_chk = lat_chk;
          sb.push_back(e);
        end
        accepted = 1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL job%0d_accept: got no accept after %0d cycles expected accept", id, waited);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d jobs pending expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  initial begin
    int   w;
    vec_t hold_job;

    rst_n    = 1'b0;
    ready_in = 1'b1;
    op_a     = '0;
    op_b     = '0;
    rm       = '0;
    idle();

    //                 div   sqrt  a             b             rm      mant_a    mant_b    exp     odd   sign  flags            lat
    vecs[0]  = mk(1'b1, 1'b0, 32'h40400000, 32'h3F800000, 3'd1, 24'hC00000, 24'h800000, 10'h080, 1'b0, 1'b0, 10'b0000000010,  1);
    vecs[1]  = mk(1'b1, 1'b0, 32'h00000001, 32'h3F800000, 3'd2, 24'h800000, 24'h800000, 10'h3EA, 1'b0, 1'b0, 10'b0000000010, 24);
    vecs[2]  = mk(1'b0, 1'b1, 32'h40800000, 32'h12345678, 3'd3, 24'h800000, 24'h000000, 10'h080, 1'b0, 1'b0, 10'b0000000001,  1);
    vecs[3]  = mk(1'b0, 1'b1, 32'h41000000, 32'h00000001, 3'd4, 24'h800000, 24'h000000, 10'h080, 1'b1, 1'b0, 10'b0000000001,  1);
    vecs[4]  = mk(1'b0, 1'b1, 32'hBF800000, 32'h00000000, 3'd0, 24'h800000, 24'h000000, 10'h07F, 1'b0, 1'b1, 10'b0000001101,  1);
    vecs[5]  = mk(1'b1, 1'b0, 32'h3F800000, 32'h00000000, 3'd1, 24'h800000, 24'h000000, 10'h0FE, 1'b0, 1'b0, 10'b0001000110,  1);
    vecs[6]  = mk(1'b1, 1'b0, 32'h00000000, 32'h00000000, 3'd2, 24'h000000, 24'h000000, 10'h07F, 1'b0, 1'b0, 10'b0011001110,  1);
    vecs[7]  = mk(1'b1, 1'b0, 32'h7F800000, 32'hFF800000, 3'd3, 24'h800000, 24'h800000, 10'h07F, 1'b0, 1'b1, 10'b1100001110,  1);
    vecs[8]  = mk(1'b1, 1'b0, 32'h7FC00000, 32'h3F800000, 3'd4, 24'hC00000, 24'h800000, 10'h0FF, 1'b0, 1'b0, 10'b0000100110,  1);
    vecs[9]  = mk(1'b1, 1'b0, 32'hC0000000, 32'h00400000, 3'd0, 24'h800000, 24'h800000, 10'h0FF, 1'b0, 1'b1, 10'b0000000010,  2);
    vecs[10] = mk(1'b0, 1'b1, 32'h00200000, 32'h00000000, 3'd1, 24'h800000, 24'h000000, 10'h03F, 1'b0, 1'b0, 10'b0000000001,  3);
    vecs[11] = mk(1'b1, 1'b1, 32'h40000000, 32'h40000000, 3'd2, 24'h800000, 24'h800000, 10'h07F, 1'b0, 1'b0, 10'b0000000010,  1);
    vecs[12] = mk(1'b0, 1'b1, 32'h80000000, 32'h00000000, 3'd3, 24'h000000, 24'h000000, 10'h03F, 1'b1, 1'b1, 10'b0010000101,  1);
    vecs[13] = mk(1'b0, 1'b1, 32'hFF800000, 32'h7FC00000, 3'd4, 24'h800000, 24'h000000, 10'h0BF, 1'b0, 1'b1, 10'b1000001101,  1);
    vecs[14] = mk(1'b1, 1'b0, 32'h00000001, 32'h00000002, 3'd0, 24'h800000, 24'h800000, 10'h07E, 1'b0, 1'b0, 10'b0000000010, 24);

    hold_job = mk(1'b0, 1'b1, 32'h41000000, 32'h00000000, 3'd5, 24'h800000, 24'h000000, 10'h080, 1'b1, 1'b0, 10'b0000000001, 1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", get_actual(), '0);
    check("reset_valid", valid, 1'b0);
    check("reset_ready", ready_so, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven jobs, one at a time, downstream always ready
    for (int i = 0; i < NVEC; i++) begin
      drive_job(vecs[i], i, 1'b1, 1'b1, w);
      idle();
      wait_drain();
    end

    // Streaming: no denormals and Ready_SI=1 must give one job per cycle
    drive_job(vecs[0], 100, 1'b1, 1'b1, w);
    drive_job(vecs[2], 101, 1'b1, 1'b1, w);
    check("stream_stall_101", w, 0);
    drive_job(vecs[5], 102, 1'b1, 1'b1, w);
    check("stream_stall_102", w, 0);
    idle();
    wait_drain();

    // Back-pressure in DONE with a start that must be ignored, then
    // back-to-back reload on the releasing handshake
    ready_in = 1'b0;
    drive_job(vecs[0], 200, 1'b1, 1'b0, w);
    div_start  = 1'b0;
    sqrt_start = 1'b1;
    op_a       = hold_job.a;
    op_b       = hold_job.b;
    rm         = hold_job.rm;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", valid, 1'b1);
      check("hold_ready", ready_so, 1'b0);
      check("hold_mant_a", mant_a, 24'hC00000);
      check("hold_exp", $unsigned(exp_o), 10'h080);
      check("hold_div_en", div_en, 1'b1);
      @(posedge clk);
      #1;
    end
    ready_in = 1'b1;
    @(negedge clk);
    check("b2b_ready", ready_so, 1'b1);
    if (ready_so) begin
      sb_t e;
      e.id = 201; e.res = hold_job.res; e.lat = 1; e.cyc = cyc; e.lat_chk = 1'b1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    check("b2b_valid", valid, 1'b1);
    wait_drain();

    // Reset while normalizing aborts the job
    drive_job(vecs[1], 300, 1'b0, 1'b0, w);
    idle();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("norm_valid_low", valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("norm_reset_outputs", get_actual(), '0);
    check("norm_reset_valid", valid, 1'b0);
    check("norm_reset_ready", ready_so, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Recovery after the aborted job
    drive_job(vecs[9], 400, 1'b1, 1'b1, w);
    idle();
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
